// File: rtl/hex_entry.sv
// Hex keypad word editor: collects up to four hex digits, moves a target
// address cursor, and issues a held write request on Enter.
//
// state    | meaning
// EDIT     | accepting keys into the edit buffer
// WAIT_ACK | write pending, keys rejected until wr_ack
module hex_entry #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  key_valid,
  input  logic [7:0]            key_ascii,
  input  logic                  wr_ack,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] edit_value,
  output logic [2:0]            digit_count,
  output logic [ADDR_WIDTH-1:0] cursor_addr,
  output logic                  bad_key
);

  typedef enum logic {EDIT, WAIT_ACK} state_t;

  localparam logic [7:0] KEY_ENTER = 8'h0D;
  localparam logic [7:0] KEY_BS    = 8'h08;
  localparam logic [7:0] KEY_ESC   = 8'h1B;
  localparam logic [7:0] KEY_PLUS  = 8'h2B;
  localparam logic [7:0] KEY_MINUS = 8'h2D;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t     state;
  logic       is_hex;
  logic [3:0] nibble;

  // Upper and lower case letters share the same low nibble, so one offset covers both.
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'h0;
    if (key_ascii >= 8'h30 && key_ascii <= 8'h39) begin
      is_hex = 1'b1;
      nibble = key_ascii[3:0];
    end else if ((key_ascii >= 8'h41 && key_ascii <= 8'h46) ||
                 (key_ascii >= 8'h61 && key_ascii <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = key_ascii[3:0] + 4'd9;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= EDIT;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      edit_value  <= '0;
      digit_count <= 3'd0;
      cursor_addr <= '0;
      bad_key     <= 1'b0;
    end else begin
      bad_key <= 1'b0;
      case (state)
        EDIT: begin
          if (key_valid) begin
            if (is_hex) begin
              if (digit_count < 3'd4) begin
                edit_value  <= {edit_value[DATA_WIDTH-5:0], nibble};
                digit_count <= digit_count + 3'd1;
              end else begin
                bad_key <= 1'b1;
              end
            end else begin
              case (key_ascii)
                KEY_BS: begin
                  if (digit_count != 3'd0) begin
                    edit_value  <= {4'h0, edit_value[DATA_WIDTH-1:4]};
                    digit_count <= digit_count - 3'd1;
                  end else begin
                    bad_key <= 1'b1;
                  end
                end
                KEY_ESC: begin
                  edit_value  <= '0;
                  digit_count <= 3'd0;
                end
                KEY_PLUS:  cursor_addr <= cursor_addr + ADDR_ONE;
                KEY_MINUS: cursor_addr <= cursor_addr - ADDR_ONE;
                KEY_ENTER: begin
                  if (digit_count != 3'd0) begin
                    wr_req  <= 1'b1;
                    wr_addr <= cursor_addr;
                    wr_data <= edit_value;
                    state   <= WAIT_ACK;
                  end else begin
                    bad_key <= 1'b1;
                  end
                end
                default: bad_key <= 1'b1;
              endcase
            end
          end
        end
        WAIT_ACK: begin
          if (key_valid) bad_key <= 1'b1;
          if (wr_ack) begin
            wr_req      <= 1'b0;
            cursor_addr <= cursor_addr + ADDR_ONE;
            edit_value  <= '0;
            digit_count <= 3'd0;
            state       <= EDIT;
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry: table of key vectors plus hand-written
// sequences for the delayed acknowledge and reset-during-write cases.
module tb_hex_entry;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_ascii = 8'h00;
  logic        wr_ack = 1'b0;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] edit_value;
  logic [2:0]  digit_count;
  logic [7:0]  cursor_addr;
  logic        bad_key;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        kv;
    logic [7:0]  key;
    logic        ack;
    logic [15:0] e_val;
    logic [2:0]  e_cnt;
    logic [7:0]  e_cur;
    logic        e_bad;
    logic        e_req;
    logic [7:0]  e_addr;
    logic [15:0] e_data;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  hex_entry #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .resetN(resetN), .key_valid(key_valid), .key_ascii(key_ascii),
    .wr_ack(wr_ack), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .edit_value(edit_value), .digit_count(digit_count),
    .cursor_addr(cursor_addr), .bad_key(bad_key)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic kv, input logic [7:0] key, input logic ack,
                              input logic [15:0] v, input logic [2:0] c, input logic [7:0] cur,
                              input logic bad, input logic req, input logic [7:0] a,
                              input logic [15:0] d);
    vec_t r;
    r = '{kv, key, ack, v, c, cur, bad, req, a, d};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " wr_req"}, 32'(wr_req), 32'h0);
    chk({tag, " wr_addr"}, 32'(wr_addr), 32'h0);
    chk({tag, " wr_data"}, 32'(wr_data), 32'h0);
    chk({tag, " edit_value"}, 32'(edit_value), 32'h0);
    chk({tag, " digit_count"}, 32'(digit_count), 32'h0);
    chk({tag, " cursor_addr"}, 32'(cursor_addr), 32'h0);
    chk({tag, " bad_key"}, 32'(bad_key), 32'h0);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    key_valid = v.kv;
    key_ascii = v.key;
    wr_ack    = v.ack;
    sb.push_back(v);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    wr_ack    = 1'b0;
    if (sb.size() == 0) begin
      chk("scoreboard empty", 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      chk("edit_value", 32'(edit_value), 32'(e.e_val));
      chk("digit_count", 32'(digit_count), 32'(e.e_cnt));
      chk("cursor_addr", 32'(cursor_addr), 32'(e.e_cur));
      chk("bad_key", 32'(bad_key), 32'(e.e_bad));
      chk("wr_req", 32'(wr_req), 32'(e.e_req));
      if (e.e_req) begin
        chk("wr_addr", 32'(wr_addr), 32'(e.e_addr));
        chk("wr_data", 32'(wr_data), 32'(e.e_data));
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check_all_zero(tag);
    @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    // Basic entry and commit with ack held high.
    tbl.push_back(mk(1, 8'h31, 1, 16'h0001, 1, 8'h00, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h61, 1, 16'h001A, 2, 8'h00, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h42, 1, 16'h01AB, 3, 8'h00, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h33, 1, 16'h1AB3, 4, 8'h00, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h0D, 1, 16'h1AB3, 4, 8'h00, 0, 1, 8'h00, 16'h1AB3));
    tbl.push_back(mk(0, 8'h00, 1, 16'h0000, 0, 8'h01, 0, 0, 8'h00, 16'h0000));
    // Overflow digit and backspace.
    tbl.push_back(mk(1, 8'h31, 0, 16'h0001, 1, 8'h01, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h32, 0, 16'h0012, 2, 8'h01, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h33, 0, 16'h0123, 3, 8'h01, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h34, 0, 16'h1234, 4, 8'h01, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h35, 0, 16'h1234, 4, 8'h01, 1, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h08, 0, 16'h0123, 3, 8'h01, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h1B, 0, 16'h0000, 0, 8'h01, 0, 0, 8'h00, 16'h0000));
    // Empty-buffer Enter/Backspace, invalid key, Esc, cursor moves.
    tbl.push_back(mk(1, 8'h0D, 0, 16'h0000, 0, 8'h01, 1, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h08, 0, 16'h0000, 0, 8'h01, 1, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h47, 0, 16'h0000, 0, 8'h01, 1, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h39, 0, 16'h0009, 1, 8'h01, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h1B, 0, 16'h0000, 0, 8'h01, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h66, 0, 16'h000F, 1, 8'h01, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h2B, 0, 16'h000F, 1, 8'h02, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h46, 0, 16'h00FF, 2, 8'h02, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h2D, 0, 16'h00FF, 2, 8'h01, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(0, 8'h47, 1, 16'h00FF, 2, 8'h01, 0, 0, 8'h00, 16'h0000));
    tbl.push_back(mk(1, 8'h40, 0, 16'h00FF, 2, 8'h01, 1, 0, 8'h00, 16'h0000));

    #1;
    check_all_zero("reset");
    @(negedge clk);
    resetN = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Decrement wraps from reset, then a commit with ack delayed three cycles.
    do_reset("reset2");
    step(mk(1, 8'h2D, 0, 16'h0000, 0, 8'hFF, 0, 0, 8'h00, 16'h0000));
    step(mk(1, 8'h37, 0, 16'h0007, 1, 8'hFF, 0, 0, 8'h00, 16'h0000));
    step(mk(1, 8'h0D, 0, 16'h0007, 1, 8'hFF, 0, 1, 8'hFF, 16'h0007));
    step(mk(0, 8'h00, 0, 16'h0007, 1, 8'hFF, 0, 1, 8'hFF, 16'h0007));
    step(mk(0, 8'h00, 0, 16'h0007, 1, 8'hFF, 0, 1, 8'hFF, 16'h0007));
    step(mk(1, 8'h35, 0, 16'h0007, 1, 8'hFF, 1, 1, 8'hFF, 16'h0007));
    step(mk(0, 8'h00, 1, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000));
    step(mk(1, 8'h2B, 0, 16'h0000, 0, 8'h01, 0, 0, 8'h00, 16'h0000));

    // Reset while a write is pending abandons it.
    step(mk(1, 8'h41, 0, 16'h000A, 1, 8'h01, 0, 0, 8'h00, 16'h0000));
    step(mk(1, 8'h0D, 0, 16'h000A, 1, 8'h01, 0, 1, 8'h01, 16'h000A));
    do_reset("reset_wait");
    step(mk(0, 8'h00, 1, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000));
    step(mk(0, 8'h00, 1, 16'h0000, 0, 8'h00, 0, 0, 8'h00, 16'h0000));
    step(mk(1, 8'h32, 0, 16'h0002, 1, 8'h00, 0, 0, 8'h00, 16'h0000));

    chk("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/hex_entry.md
HEX_ENTRY -- requirements
Module: hex_entry

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the edited word; fixed at 16 (4 nibbles).
REQ-002 Parameter ADDR_WIDTH, default 8, width of the target memory address.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 resetN  input  1  asynchronous active-low reset.
REQ-005 key_valid  input  1  one-cycle strobe; key_ascii is valid while high.
REQ-006 key_ascii  input  8  ASCII code of the pressed key.
REQ-007 wr_ack  input  1  memory accepts the pending write in a cycle where wr_req and wr_ack are both high.
REQ-008 wr_req  output  1  write request, held until acknowledged.
REQ-009 wr_addr  output  ADDR_WIDTH  write address, stable while wr_req is high.
REQ-010 wr_data  output  DATA_WIDTH  write data, stable while wr_req is high.
REQ-011 edit_value  output  DATA_WIDTH  word being entered; feeds the hex display.
REQ-012 digit_count  output  3  number of digits entered so far, 0..4.
REQ-013 cursor_addr  output  ADDR_WIDTH  address the next commit writes to.
REQ-014 bad_key  output  1  one-cycle pulse on a rejected key.

Function
REQ-015 FSM states: EDIT and WAIT_ACK.
REQ-016 Key classes: hex digit = 0x30-0x39, 0x41-0x46, 0x61-0x66 (value 0-15; upper and lower case equal); Enter 0x0D; Backspace 0x08; Esc 0x1B; '+' 0x2B; '-' 0x2D; every other code is invalid.
REQ-017 Keys act only in EDIT, on the cycle key_valid is high.
- REQ-017a Results are visible on the next clock edge (latency 1).
REQ-018 Hex digit, digit_count<4: edit_value <= {edit_value[11:0], nibble}; digit_count increments.
REQ-019 Hex digit, digit_count==4: edit_value and digit_count unchanged; bad_key pulses.
REQ-020 Backspace, digit_count>0: edit_value <= {4'h0, edit_value[15:4]}; digit_count decrements.
REQ-021 Backspace, digit_count==0: no change; bad_key pulses.
REQ-022 Esc: edit_value <= 0; digit_count <= 0; cursor_addr unchanged.
REQ-023 '+': cursor_addr increments modulo 2^ADDR_WIDTH (max wraps to 0).
- REQ-023a '-': cursor_addr decrements modulo 2^ADDR_WIDTH (0 wraps to max).
- REQ-023b Edit buffer unchanged in both cases.
REQ-024 Enter, digit_count>0:
- wr_req <= 1; wr_addr <= cursor_addr; wr_data <= edit_value; state <= WAIT_ACK.
REQ-025 Enter, digit_count==0: no write; bad_key pulses.
REQ-026 WAIT_ACK: wr_req, wr_addr and wr_data hold until the cycle wr_ack is high.
- REQ-026a On that edge: wr_req <= 0; cursor_addr increments (wrapping); edit_value <= 0; digit_count <= 0; state <= EDIT.
REQ-027 WAIT_ACK: every key_valid is dropped with no effect, and bad_key pulses.
REQ-028 wr_ack while in EDIT is ignored.
REQ-029 wr_ack in the same cycle wr_req first rises is legal.
- REQ-029a wr_req is then high for exactly one cycle.
REQ-030 Invalid key in EDIT: no state change; bad_key pulses.
REQ-031 bad_key is registered and is high for exactly one cycle per rejected key.

Reset
REQ-032 resetN low forces all of the following immediately, independent of clk:
- state EDIT; wr_req 0; wr_addr 0; wr_data 0; edit_value 0; digit_count 0; cursor_addr 0; bad_key 0.
REQ-033 Reset during WAIT_ACK abandons the write.
- wr_req drops asynchronously; no retry after reset release.
REQ-034 The first key is processed on the first rising edge after resetN deasserts.

Verification
REQ-035 Keys '1','a','B','3' then Enter; wr_ack held high.
- edit_value 0x1AB3 and digit_count 4 before Enter.
- One-cycle wr_req with wr_addr 0x00, wr_data 0x1AB3.
- Afterwards cursor_addr 0x01 and edit_value 0.
REQ-036 Keys '1','2','3','4','5'.
- edit_value 0x1234; bad_key pulses once on '5'.
- Then Backspace -> edit_value 0x0123, digit_count 3.
REQ-037 '-' from reset -> cursor_addr 0xFF.
- Then '7', Enter, with wr_ack delayed 3 cycles.
- wr_req high 4 cycles at wr_addr 0xFF, wr_data 0x0007.
- A key sent during the wait gets bad_key and is dropped; cursor_addr ends at 0x00.
REQ-038 Enter with digit_count 0 -> no wr_req, bad_key pulses. Backspace with digit_count 0 -> bad_key pulses.
REQ-039 Key 'G' (0x47) -> bad_key pulses, outputs unchanged.
- Then '9', Esc -> edit_value 0, digit_count 0.
REQ-040 Assert resetN in WAIT_ACK.
- wr_req falls before the next edge; all outputs 0.
- After release, wr_ack pulses cause no write.
